// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared constants, packed-word layout, FSM states and gray weighting
package win_pkg;

  localparam int DEF_IMG_W = 160;
  localparam int DEF_IMG_H = 115;
  localparam int ORIGIN_X  = 100;
  localparam int ORIGIN_Y  = 100;

  // Field layout of the 96-bit word, shared with the operation stage decoder
  localparam int GRAY_HI  = 95;
  localparam int GRAY_LO  = 88;
  localparam int LEFT_HI  = 87;
  localparam int LEFT_LO  = 80;
  localparam int RIGHT_HI = 79;
  localparam int RIGHT_LO = 72;
  localparam int UP_HI    = 71;
  localparam int UP_LO    = 64;
  localparam int DOWN_HI  = 63;
  localparam int DOWN_LO  = 56;
  localparam int LU_HI    = 55;
  localparam int LU_LO    = 48;
  localparam int LD_HI    = 47;
  localparam int LD_LO    = 40;
  localparam int RU_HI    = 39;
  localparam int RU_LO    = 32;
  localparam int RD_HI    = 31;
  localparam int RD_LO    = 24;
  localparam int BLUE_HI  = 23;
  localparam int BLUE_LO  = 16;
  localparam int GREEN_HI = 15;
  localparam int GREEN_LO = 8;
  localparam int RED_HI   = 7;
  localparam int RED_LO   = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  function automatic logic [7:0] gray_weight(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
    logic [8:0] s;
    s = 9'(r >> 2) + 9'(r >> 5) + 9'(g >> 1) + 9'(g >> 4) + 9'(b >> 4) + 9'(b >> 5);
    return s[7:0];
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - circular single-clock line delay, read-before-write on advance
module line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 160
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv) ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Contents are never cleared: stale entries are always masked by edge clamping
  always_ff @(posedge clk) begin
    if (adv) mem[ptr_q] <= wr_data;
  end

  assign rd_data = mem[ptr_q];

endmodule

// File: rtl/window3x3_packer.sv
// rtl/window3x3_packer.sv - raster RGB to clamped 3x3 gray window packer
module window3x3_packer
  import win_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int CW    = 10
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [7:0]    in_r,
  input  logic [7:0]    in_g,
  input  logic [7:0]    in_b,
  output logic [95:0]   dout,
  output logic          out_valid,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic          frame_done
);

  localparam logic [CW-1:0] X_LAST    = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(IMG_H - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(IMG_W);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] px_q, px_d, py_q, py_d;
  logic [CW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [CW-1:0] tick_q, tick_d;
  logic          accept, adv, emit;

  assign in_ready = (state_q != ST_FLUSH);
  assign accept   = in_valid && in_ready;

  // px/py track the pixel being accepted, ox/oy the next centre to emit
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    tick_d  = tick_q;
    adv     = 1'b0;
    emit    = 1'b0;
    if (accept && in_sof) begin
      adv     = 1'b1;
      state_d = ST_FILL;
      px_d    = CW'(1);
      py_d    = '0;
      ox_d    = '0;
      oy_d    = '0;
    end else begin
      case (state_q)
        ST_FILL, ST_RUN: begin
          if (accept) begin
            adv  = 1'b1;
            px_d = (px_q == X_LAST) ? '0 : px_q + CW'(1);
            if (px_q == X_LAST) py_d = (py_q == Y_LAST) ? '0 : py_q + CW'(1);
            if (state_q == ST_FILL) begin
              if (px_q == '0 && py_q == CW'(1)) state_d = ST_RUN;
            end else begin
              emit = 1'b1;
              if (px_q == X_LAST && py_q == Y_LAST) begin
                state_d = ST_FLUSH;
                tick_d  = '0;
              end
            end
          end
        end
        ST_FLUSH: begin
          adv    = 1'b1;
          emit   = 1'b1;
          tick_d = tick_q + CW'(1);
          if (tick_q == TICK_LAST) begin
            state_d = ST_IDLE;
            tick_d  = '0;
          end
        end
        default: ;
      endcase
    end
    if (emit) begin
      ox_d = (ox_q == X_LAST) ? '0 : ox_q + CW'(1);
      if (ox_q == X_LAST) oy_d = (oy_q == Y_LAST) ? '0 : oy_q + CW'(1);
    end
  end

  // Stage G: gray of the newest pixel plus the centre coordinate it triggers
  logic          g_adv_q, g_adv_d, g_emit_q, g_emit_d;
  logic [7:0]    g_gray_q, g_gray_d;
  logic [23:0]   g_rgb_q, g_rgb_d;
  logic [CW-1:0] g_cx_q, g_cx_d, g_cy_q, g_cy_d;

  always_comb begin
    g_adv_d  = adv;
    g_emit_d = emit;
    g_gray_d = g_gray_q;
    g_rgb_d  = g_rgb_q;
    g_cx_d   = g_cx_q;
    g_cy_d   = g_cy_q;
    if (adv) begin
      g_gray_d = gray_weight(in_r, in_g, in_b);
      g_rgb_d  = {in_b, in_g, in_r};
    end
    if (emit) begin
      g_cx_d = ox_q;
      g_cy_d = oy_q;
    end
  end

  logic [7:0]  mid_raw, top_raw;
  logic [23:0] rgb_raw;

  line_buffer #(.WIDTH(8), .DEPTH(IMG_W)) u_lb_mid (
    .clk(pixel_clk), .reset(reset), .adv(g_adv_q), .wr_data(g_gray_q), .rd_data(mid_raw)
  );
  line_buffer #(.WIDTH(8), .DEPTH(IMG_W)) u_lb_top (
    .clk(pixel_clk), .reset(reset), .adv(g_adv_q), .wr_data(mid_raw), .rd_data(top_raw)
  );
  line_buffer #(.WIDTH(24), .DEPTH(IMG_W)) u_lb_rgb (
    .clk(pixel_clk), .reset(reset), .adv(g_adv_q), .wr_data(g_rgb_q), .rd_data(rgb_raw)
  );

  // Columns {top,mid,bot}: c1 = pixel p-1 (holds the centre), c2 = p-2, incoming = p
  logic [23:0] c1_q, c1_d, c2_q, c2_d, col_r;
  logic [23:0] rgb_c_q, rgb_c_d;
  logic        top_row, bot_row, left_col, right_col;
  logic [7:0]  lt, lm, lb, ct, cm, cb, rt, rm, rb;

  assign col_r = {top_raw, mid_raw, g_gray_q};

  always_comb begin
    top_row   = (g_cy_q == '0);
    bot_row   = (g_cy_q == Y_LAST);
    left_col  = (g_cx_q == '0);
    right_col = (g_cx_q == X_LAST);
    {lt, lm, lb} = c2_q;
    {ct, cm, cb} = c1_q;
    {rt, rm, rb} = col_r;
    if (top_row) begin
      lt = lm;
      ct = cm;
      rt = rm;
    end
    if (bot_row) begin
      lb = lm;
      cb = cm;
      rb = rm;
    end
    if (left_col) begin
      lt = ct;
      lm = cm;
      lb = cb;
    end
    if (right_col) begin
      rt = ct;
      rm = cm;
      rb = cb;
    end
  end

  logic [95:0]   dout_q, dout_d;
  logic          out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic [CW-1:0] out_x_q, out_x_d, out_y_q, out_y_d;

  always_comb begin
    dout_d       = dout_q;
    out_valid_d  = g_emit_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    frame_done_d = g_emit_q && right_col && bot_row;
    c1_d         = c1_q;
    c2_d         = c2_q;
    rgb_c_d      = rgb_c_q;
    if (g_emit_q) begin
      dout_d[GRAY_HI:GRAY_LO]   = cm;
      dout_d[LEFT_HI:LEFT_LO]   = lm;
      dout_d[RIGHT_HI:RIGHT_LO] = rm;
      dout_d[UP_HI:UP_LO]       = ct;
      dout_d[DOWN_HI:DOWN_LO]   = cb;
      dout_d[LU_HI:LU_LO]       = lt;
      dout_d[LD_HI:LD_LO]       = lb;
      dout_d[RU_HI:RU_LO]       = rt;
      dout_d[RD_HI:RD_LO]       = rb;
      dout_d[BLUE_HI:BLUE_LO]   = rgb_c_q[23:16];
      dout_d[GREEN_HI:GREEN_LO] = rgb_c_q[15:8];
      dout_d[RED_HI:RED_LO]     = rgb_c_q[7:0];
      out_x_d = g_cx_q;
      out_y_d = g_cy_q;
    end
    if (g_adv_q) begin
      c2_d    = c1_q;
      c1_d    = col_r;
      rgb_c_d = rgb_raw;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      px_q         <= '0;
      py_q         <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      tick_q       <= '0;
      g_adv_q      <= 1'b0;
      g_emit_q     <= 1'b0;
      g_gray_q     <= '0;
      g_rgb_q      <= '0;
      g_cx_q       <= '0;
      g_cy_q       <= '0;
      c1_q         <= '0;
      c2_q         <= '0;
      rgb_c_q      <= '0;
      dout_q       <= '0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      py_q         <= py_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      tick_q       <= tick_d;
      g_adv_q      <= g_adv_d;
      g_emit_q     <= g_emit_d;
      g_gray_q     <= g_gray_d;
      g_rgb_q      <= g_rgb_d;
      g_cx_q       <= g_cx_d;
      g_cy_q       <= g_cy_d;
      c1_q         <= c1_d;
      c2_q         <= c2_d;
      rgb_c_q      <= rgb_c_d;
      dout_q       <= dout_d;
      out_valid_q  <= out_valid_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout       = dout_q;
  assign out_valid  = out_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window3x3_packer.sv
// tb/tb_window3x3_packer.sv - scoreboard bench with clamped-window reference model
module tb_window3x3_packer;

  localparam int W = 160;
  localparam int H = 115;
  localparam int N = W * H;

  typedef struct packed {
    logic [95:0] d;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
  logic        in_ready, out_valid, frame_done;
  logic [95:0] dout;
  logic [9:0]  out_x, out_y;

  window3x3_packer #(.IMG_W(W), .IMG_H(H), .CW(10)) dut (
    .pixel_clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_r(in_r), .in_g(in_g), .in_b(in_b), .dout(dout),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [23:0] pix [N];
  exp_t        exp_q[$];
  int          trig_q[$];
  int          vectors = 0;
  int          fails = 0;
  int          edge_cnt = 0;
  int          fd_count = 0;
  logic [95:0] last_dout = '0;

  function automatic int gray_of(input logic [23:0] p);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    return ((r >> 2) + (r >> 5) + (g >> 1) + (g >> 4) + (b >> 4) + (b >> 5)) % 256;
  endfunction

  function automatic logic [7:0] gp(input int x, input int y);
    int cx, cy;
    cx = (x < 0) ? 0 : (x >= W) ? W - 1 : x;
    cy = (y < 0) ? 0 : (y >= H) ? H - 1 : y;
    return 8'(gray_of(pix[cy * W + cx]));
  endfunction

  // Centres whose whole window has been delivered before the frame ends or is cut
  task automatic model_frame(input int n_acc);
    int   last;
    exp_t e;
    last = (n_acc == N) ? N - 1 : n_acc - W - 2;
    for (int c = 0; c <= last; c++) begin
      int x, y;
      x = c % W;
      y = c / W;
      e.x  = 10'(x);
      e.y  = 10'(y);
      e.fd = (c == N - 1);
      e.d  = {gp(x, y), gp(x - 1, y), gp(x + 1, y), gp(x, y - 1), gp(x, y + 1),
              gp(x - 1, y - 1), gp(x - 1, y + 1), gp(x + 1, y - 1), gp(x + 1, y + 1),
              pix[c][7:0], pix[c][15:8], pix[c][23:16]};
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    #1;
    if (reset) begin
      vectors++;
      if (out_valid !== 1'b0 || dout !== '0 || frame_done !== 1'b0) begin
        fails++;
        $display("FAIL reset_clear: out_valid=%b frame_done=%b dout=%h, required 0/0/0",
                 out_valid, frame_done, dout);
      end
      last_dout = '0;
    end else if (out_valid === 1'b1) begin
      exp_t e;
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got (%0d,%0d) dout=%h, required no output",
                 out_x, out_y, dout);
      end else begin
        e = exp_q.pop_front();
        if ({dout, out_x, out_y, frame_done} !== {e.d, e.x, e.y, e.fd}) begin
          fails++;
          $display("FAIL pixel: got (%0d,%0d) fd=%b dout=%h, required (%0d,%0d) fd=%b dout=%h",
                   out_x, out_y, frame_done, dout, e.x, e.y, e.fd, e.d);
        end
        last_dout = e.d;
      end
      vectors++;
      if (trig_q.size() == 0) begin
        fails++;
        $display("FAIL latency: output at edge %0d, required a preceding trigger", edge_cnt);
      end else begin
        int t;
        t = trig_q.pop_front();
        if (edge_cnt != t + 1) begin
          fails++;
          $display("FAIL latency: output at edge %0d, required edge %0d", edge_cnt, t + 1);
        end
      end
      if (frame_done === 1'b1) fd_count++;
    end else begin
      vectors++;
      if (frame_done !== 1'b0 || dout !== last_dout) begin
        fails++;
        $display("FAIL idle_hold: frame_done=%b dout=%h, required 0 and %h",
                 frame_done, dout, last_dout);
      end
    end
  end

  task automatic drive_beat(input logic [23:0] p, input logic sof, input int gap_pct,
                            output int acc_edge);
    logic rdy;
    int   guard;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_sof   = sof;
    {in_r, in_g, in_b} = p;
    guard = 0;
    forever begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      guard++;
      if (guard > 1000) begin
        vectors++;
        fails++;
        $display("FAIL ready_timeout: in_ready=0 after %0d cycles, required 1", guard);
        break;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    acc_edge = edge_cnt;
  endtask

  task automatic send_frame(input int n, input int gap_pct, input bit do_reset);
    int e;
    int lo;
    model_frame(n);
    e = 0;
    for (int i = 0; i < n; i++) begin
      drive_beat(pix[i], i == 0, gap_pct, e);
      if (i >= W + 1) trig_q.push_back(e);
    end
    if (n != N) return;
    for (int j = 1; j <= W + 1; j++) trig_q.push_back(e + j);
    if (do_reset) begin
      repeat (20) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_q.delete();
      trig_q.delete();
      reset = 1'b0;
      vectors++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_idle: in_ready=%b, required 1", in_ready);
      end
    end else begin
      lo = 0;
      while (in_ready === 1'b0 && lo < 1000) begin
        lo++;
        @(posedge clk);
        #1;
      end
      vectors++;
      if (lo != W + 1) begin
        fails++;
        $display("FAIL flush_len: in_ready low %0d cycles, required %0d", lo, W + 1);
      end
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (exp_q.size() != 0 || trig_q.size() != 0) begin
        fails++;
        $display("FAIL frame_count: %0d outputs missing, required 0", exp_q.size());
      end
    end
  endtask

  initial begin
    int e;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < N; i++) pix[i] = 24'h808080;
    send_frame(N, 0, 1'b0);

    for (int i = 0; i < N; i++) pix[i] = 24'($urandom);
    send_frame(3000, 0, 1'b0);

    for (int i = 0; i < N; i++) pix[i] = {3{8'(i % W)}};
    send_frame(N, 0, 1'b0);

    for (int i = 0; i < N; i++) pix[i] = 24'($urandom);
    send_frame(N, 50, 1'b1);

    for (int k = 0; k < 5; k++) drive_beat(24'($urandom), 1'b0, 0, e);
    for (int i = 0; i < N; i++) pix[i] = 24'($urandom);
    send_frame(200, 0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0 || trig_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d outputs outstanding, required 0", exp_q.size());
    end
    vectors++;
    if (fd_count != 2) begin
      fails++;
      $display("FAIL frame_done_count: got %0d, required 2", fd_count);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
